// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// Module  : vga_pkg
// Brief   : Shared 640x480 geometry, RGB444 colours and motion FSM encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] BLUE  = 12'h00F;

  typedef logic [1:0] motion_state_t;
  localparam motion_state_t ST_WAIT  = 2'd0;
  localparam motion_state_t ST_UPD_X = 2'd1;
  localparam motion_state_t ST_UPD_Y = 2'd2;
endpackage

`default_nettype wire

// File: rtl/ball_motion.sv
//------------------------------------------------------------------------------
// Module  : ball_motion
// Brief   : Per-frame ball position/direction update, bounce pulse, colour.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ball_motion
  import vga_pkg::*;
#(
  parameter int BALL_SIZE = 16,
  parameter int X0        = 312,
  parameter int Y0        = 232
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_vs,
  input  logic        i_pause,
  input  logic [2:0]  i_speed,
  output logic [9:0]  o_bx,
  output logic [8:0]  o_by,
  output logic [11:0] o_ball_rgb,
  output logic        o_hit
);
  localparam logic [10:0] X_MAX = 11'(H_RES - BALL_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_RES - BALL_SIZE);

  motion_state_t r_state, w_next;
  logic        r_vs_prev, r_dx, r_dy, r_hit_x, r_hit, r_red;
  logic [9:0]  r_bx;
  logic [8:0]  r_by;
  logic [2:0]  r_spd;
  logic        w_vs_fall, w_start, w_upd_x, w_upd_y;
  logic [10:0] w_x_sum, w_y_sum;
  logic [9:0]  w_x_new;
  logic [8:0]  w_y_new;
  logic        w_x_hit, w_y_hit;

  assign w_vs_fall = i_pix_stb && r_vs_prev && !i_vs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_WAIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT:  if (w_vs_fall && !i_pause) w_next = ST_UPD_X;
      ST_UPD_X: w_next = ST_UPD_Y;
      ST_UPD_Y: w_next = ST_WAIT;
      default:  w_next = ST_WAIT;
    endcase
  end

  always_comb begin
    w_start = (r_state == ST_WAIT) && w_vs_fall && !i_pause;
    w_upd_x = (r_state == ST_UPD_X);
    w_upd_y = (r_state == ST_UPD_Y);
  end

  // 11-bit sums so bx+spd near the right/bottom limit cannot wrap.
  always_comb begin
    w_x_sum = {1'b0, r_bx} + {8'd0, r_spd};
    w_x_new = w_x_sum[9:0];
    w_x_hit = 1'b0;
    if (r_dx) begin
      if (w_x_sum >= X_MAX) begin
        w_x_new = X_MAX[9:0];
        w_x_hit = 1'b1;
      end
    end else begin
      w_x_new = r_bx - {7'd0, r_spd};
      if (r_bx <= {7'd0, r_spd}) begin
        w_x_new = '0;
        w_x_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_y_sum = {2'b0, r_by} + {8'd0, r_spd};
    w_y_new = w_y_sum[8:0];
    w_y_hit = 1'b0;
    if (r_dy) begin
      if (w_y_sum >= Y_MAX) begin
        w_y_new = Y_MAX[8:0];
        w_y_hit = 1'b1;
      end
    end else begin
      w_y_new = r_by - {6'd0, r_spd};
      if (r_by <= {6'd0, r_spd}) begin
        w_y_new = '0;
        w_y_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_prev <= 1'b1;
      r_bx      <= 10'(X0);
      r_by      <= 9'(Y0);
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
      r_spd     <= '0;
      r_hit_x   <= 1'b0;
      r_hit     <= 1'b0;
      r_red     <= 1'b0;
    end else begin
      if (i_pix_stb) r_vs_prev <= i_vs;
      if (w_start)   r_spd     <= i_speed;
      if (w_upd_x) begin
        r_bx    <= w_x_new;
        r_hit_x <= w_x_hit;
        if (w_x_hit) r_dx <= !r_dx;
      end
      if (w_upd_y) begin
        r_by <= w_y_new;
        if (w_y_hit) r_dy <= !r_dy;
      end
      // Corner hits merge into the single pulse issued after UPD_Y.
      r_hit <= w_upd_y && (r_hit_x || w_y_hit);
      if (w_upd_y && (r_hit_x || w_y_hit)) r_red <= !r_red;
    end
  end

  assign o_bx       = r_bx;
  assign o_by       = r_by;
  assign o_hit      = r_hit;
  assign o_ball_rgb = r_red ? RED : WHITE;
endmodule

`default_nettype wire

// File: rtl/ball_renderer.sv
//------------------------------------------------------------------------------
// Module  : ball_renderer
// Brief   : Two-stage strobe-gated pixel pipeline drawing ball and border.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ball_renderer
  import vga_pkg::*;
#(
  parameter int BALL_SIZE = 16,
  parameter int X0        = 312,
  parameter int Y0        = 232
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_active,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic       i_pause,
  input  logic [2:0] i_speed,
  output logic       o_hs,
  output logic       o_vs,
  output logic [3:0] o_r,
  output logic [3:0] o_g,
  output logic [3:0] o_b,
  output logic       o_hit
);
  logic [9:0]  w_bx;
  logic [8:0]  w_by;
  logic [11:0] w_ball_rgb;
  logic        w_in_ball, w_border;
  logic [11:0] w_rgb;
  logic        r1_in_ball, r1_border, r1_active, r1_hs, r1_vs;
  logic [11:0] r2_rgb;
  logic        r2_hs, r2_vs;

  ball_motion #(
    .BALL_SIZE(BALL_SIZE),
    .X0       (X0),
    .Y0       (Y0)
  ) u_motion (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_pix_stb (i_pix_stb),
    .i_vs      (i_vs),
    .i_pause   (i_pause),
    .i_speed   (i_speed),
    .o_bx      (w_bx),
    .o_by      (w_by),
    .o_ball_rgb(w_ball_rgb),
    .o_hit     (o_hit)
  );

  always_comb begin
    w_in_ball = ({1'b0, i_x} >= {1'b0, w_bx}) &&
                ({1'b0, i_x} <  ({1'b0, w_bx} + 11'(BALL_SIZE))) &&
                ({1'b0, i_y} >= {1'b0, w_by}) &&
                ({1'b0, i_y} <  ({1'b0, w_by} + 10'(BALL_SIZE)));
    w_border  = (i_x == '0) || (i_x == 10'(H_RES - 1)) ||
                (i_y == '0) || (i_y == 9'(V_RES - 1));
  end

  // Ball takes priority over the border.
  always_comb begin
    w_rgb = BLACK;
    if (r1_active) begin
      if (r1_in_ball)     w_rgb = w_ball_rgb;
      else if (r1_border) w_rgb = BLUE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_in_ball <= 1'b0;
      r1_border  <= 1'b0;
      r1_active  <= 1'b0;
      r1_hs      <= 1'b1;
      r1_vs      <= 1'b1;
      r2_rgb     <= BLACK;
      r2_hs      <= 1'b1;
      r2_vs      <= 1'b1;
    end else if (i_pix_stb) begin
      r1_in_ball <= w_in_ball;
      r1_border  <= w_border;
      r1_active  <= i_active;
      r1_hs      <= i_hs;
      r1_vs      <= i_vs;
      r2_rgb     <= w_rgb;
      r2_hs      <= r1_hs;
      r2_vs      <= r1_vs;
    end
  end

  assign o_hs = r2_hs;
  assign o_vs = r2_vs;
  assign o_r  = r2_rgb[11:8];
  assign o_g  = r2_rgb[7:4];
  assign o_b  = r2_rgb[3:0];
endmodule

`default_nettype wire

// File: tb/tb_ball_renderer.sv
//------------------------------------------------------------------------------
// Module  : tb_ball_renderer
// Brief   : Directed self-checking bench for ball_renderer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ball_renderer;
  import vga_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, pix_stb = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, active = 1'b0, pause = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic [2:0] speed = '0;
  logic       hs_o, vs_o, hit_o, c_hs_o, c_vs_o, c_hit_o;
  logic [3:0] r_o, g_o, b_o, c_r_o, c_g_o, c_b_o;
  logic [11:0] rgb;

  int tests = 0, fails = 0;
  int hits_dut = 0, hits_cor = 0, busy_dut = 0;

  always #5 clk = ~clk;

  ball_renderer u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_hs(hs), .i_vs(vs),
    .i_active(active), .i_x(x), .i_y(y), .i_pause(pause), .i_speed(speed),
    .o_hs(hs_o), .o_vs(vs_o), .o_r(r_o), .o_g(g_o), .o_b(b_o), .o_hit(hit_o)
  );

  ball_renderer #(.BALL_SIZE(16), .X0(624), .Y0(464)) u_corner (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_hs(hs), .i_vs(vs),
    .i_active(active), .i_x(x), .i_y(y), .i_pause(pause), .i_speed(speed),
    .o_hs(c_hs_o), .o_vs(c_vs_o), .o_r(c_r_o), .o_g(c_g_o), .o_b(c_b_o),
    .o_hit(c_hit_o)
  );

  always @(negedge clk) begin
    if (hit_o)   hits_dut++;
    if (c_hit_o) hits_cor++;
    if (u_dut.u_motion.r_state != ST_WAIT) busy_dut++;
  end

  task automatic strobe();
    @(negedge clk) pix_stb = 1'b1;
    @(negedge clk) pix_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    hs = 1'b1; vs = 1'b1; active = 1'b0; pause = 1'b0; speed = '0;
    x = '0; y = '0;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic frame();
    vs = 1'b0;
    strobe();
    vs = 1'b1;
    strobe();
    idle(4);
  endtask

  task automatic render_px(input logic [9:0] px, input logic [8:0] py,
                           output logic [11:0] col);
    x = px; y = py; active = 1'b1; hs = 1'b1;
    strobe();
    active = 1'b0;
    strobe();
    col = {r_o, g_o, b_o};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      pix_stb = 1'($urandom_range(1)); hs = 1'($urandom_range(1));
      vs = 1'($urandom_range(1)); active = 1'($urandom_range(1));
      x = 10'($urandom_range(639)); y = 9'($urandom_range(479));
      speed = 3'($urandom_range(7));
    end
    pix_stb = 1'b0;
    tests++;
    if ({hs_o, vs_o, r_o, g_o, b_o, hit_o} !== {2'b11, 12'h000, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got hs=%b vs=%b rgb=%h hit=%b, expected hs=1 vs=1 rgb=000 hit=0",
               hs_o, vs_o, {r_o, g_o, b_o}, hit_o);
    end
    tests++;
    if ({u_dut.u_motion.r_bx, u_dut.u_motion.r_by} !== {10'd312, 9'd232}) begin
      fails++;
      $display("FAIL reset_position: got (%0d,%0d) expected (312,232)",
               u_dut.u_motion.r_bx, u_dut.u_motion.r_by);
    end
    do_reset();
  endtask

  task automatic test_alignment();
    x = 10'd312; y = 9'd232; active = 1'b1; hs = 1'b0;
    strobe();
    tests++;
    if ({r_o, g_o, b_o, hs_o} !== {12'h000, 1'b1}) begin
      fails++;
      $display("FAIL align_one_strobe: got rgb=%h hs=%b expected rgb=000 hs=1",
               {r_o, g_o, b_o}, hs_o);
    end
    x = 10'd0; y = 9'd100; hs = 1'b1;
    strobe();
    tests++;
    if ({r_o, g_o, b_o, hs_o} !== {12'hFFF, 1'b0}) begin
      fails++;
      $display("FAIL align_ball: got rgb=%h hs=%b expected rgb=FFF hs=0",
               {r_o, g_o, b_o}, hs_o);
    end
    idle(3);
    tests++;
    if ({r_o, g_o, b_o, hs_o} !== {12'hFFF, 1'b0}) begin
      fails++;
      $display("FAIL align_hold: got rgb=%h hs=%b expected rgb=FFF hs=0",
               {r_o, g_o, b_o}, hs_o);
    end
    active = 1'b0;
    strobe();
    tests++;
    if ({r_o, g_o, b_o, hs_o} !== {12'h00F, 1'b1}) begin
      fails++;
      $display("FAIL align_border: got rgb=%h hs=%b expected rgb=00F hs=1",
               {r_o, g_o, b_o}, hs_o);
    end
    strobe();
    tests++;
    if ({r_o, g_o, b_o} !== 12'h000) begin
      fails++;
      $display("FAIL align_inactive: got rgb=%h expected 000", {r_o, g_o, b_o});
    end
    render_px(10'd327, 9'd247, rgb);
    tests++;
    if (rgb !== 12'hFFF) begin
      fails++;
      $display("FAIL ball_last_pixel: got %h expected FFF", rgb);
    end
    render_px(10'd328, 9'd232, rgb);
    tests++;
    if (rgb !== 12'h000) begin
      fails++;
      $display("FAIL ball_past_edge: got %h expected 000", rgb);
    end
    render_px(10'd639, 9'd479, rgb);
    tests++;
    if (rgb !== 12'h00F) begin
      fails++;
      $display("FAIL border_corner: got %h expected 00F", rgb);
    end
  endtask

  task automatic test_corner();
    int h0;
    do_reset();
    speed = 3'd1;
    h0 = hits_cor;
    frame();
    tests++;
    if (hits_cor - h0 != 1) begin
      fails++;
      $display("FAIL corner_pulses: got %0d expected 1", hits_cor - h0);
    end
    tests++;
    if ({u_corner.u_motion.r_dx, u_corner.u_motion.r_dy,
         u_corner.u_motion.r_bx, u_corner.u_motion.r_by} !== {2'b00, 10'd624, 9'd464}) begin
      fails++;
      $display("FAIL corner_state: got dx=%b dy=%b pos=(%0d,%0d) expected dx=0 dy=0 pos=(624,464)",
               u_corner.u_motion.r_dx, u_corner.u_motion.r_dy,
               u_corner.u_motion.r_bx, u_corner.u_motion.r_by);
    end
  endtask

  task automatic test_bounce();
    int h0;
    do_reset();
    speed = 3'd4;
    h0 = hits_dut;
    for (int f = 1; f <= 78; f++) begin
      frame();
      if (f == 57) begin
        tests++;
        if (u_dut.u_motion.r_by !== 9'd460 || hits_dut != h0) begin
          fails++;
          $display("FAIL bounce_f57: got by=%0d hits=%0d expected by=460 hits=0",
                   u_dut.u_motion.r_by, hits_dut - h0);
        end
      end
      if (f == 58) begin
        tests++;
        if (u_dut.u_motion.r_by !== 9'd464 || u_dut.u_motion.r_dy !== 1'b0 ||
            hits_dut - h0 != 1) begin
          fails++;
          $display("FAIL bounce_f58: got by=%0d dy=%b hits=%0d expected by=464 dy=0 hits=1",
                   u_dut.u_motion.r_by, u_dut.u_motion.r_dy, hits_dut - h0);
        end
        render_px(10'd544, 9'd464, rgb);
        tests++;
        if (rgb !== 12'hF00) begin
          fails++;
          $display("FAIL bounce_red: got %h expected F00", rgb);
        end
      end
    end
    tests++;
    if (u_dut.u_motion.r_bx !== 10'd624 || u_dut.u_motion.r_dx !== 1'b0 ||
        u_dut.u_motion.r_by !== 9'd384 || hits_dut - h0 != 2) begin
      fails++;
      $display("FAIL bounce_f78: got bx=%0d dx=%b by=%0d hits=%0d expected bx=624 dx=0 by=384 hits=2",
               u_dut.u_motion.r_bx, u_dut.u_motion.r_dx, u_dut.u_motion.r_by, hits_dut - h0);
    end
    render_px(10'd624, 9'd384, rgb);
    tests++;
    if (rgb !== 12'hFFF) begin
      fails++;
      $display("FAIL bounce_white: got %h expected FFF", rgb);
    end
  endtask

  task automatic test_pause_speed0();
    int b0, h0;
    do_reset();
    pause = 1'b1; speed = 3'd4;
    b0 = busy_dut; h0 = hits_dut;
    repeat (5) frame();
    tests++;
    if ({u_dut.u_motion.r_bx, u_dut.u_motion.r_by} !== {10'd312, 9'd232} ||
        busy_dut != b0) begin
      fails++;
      $display("FAIL pause: got pos=(%0d,%0d) busy=%0d expected pos=(312,232) busy=0",
               u_dut.u_motion.r_bx, u_dut.u_motion.r_by, busy_dut - b0);
    end
    pause = 1'b0; speed = 3'd0;
    repeat (3) frame();
    tests++;
    if ({u_dut.u_motion.r_bx, u_dut.u_motion.r_by} !== {10'd312, 9'd232} ||
        hits_dut != h0 || busy_dut - b0 != 6) begin
      fails++;
      $display("FAIL speed0: got pos=(%0d,%0d) hits=%0d busy=%0d expected pos=(312,232) hits=0 busy=6",
               u_dut.u_motion.r_bx, u_dut.u_motion.r_by, hits_dut - h0, busy_dut - b0);
    end
  endtask

  task automatic test_pause_mid_update();
    do_reset();
    speed = 3'd2;
    vs = 1'b0;
    strobe();
    pause = 1'b1;
    vs = 1'b1;
    idle(4);
    tests++;
    if ({u_dut.u_motion.r_bx, u_dut.u_motion.r_by} !== {10'd314, 9'd234}) begin
      fails++;
      $display("FAIL pause_mid_update: got (%0d,%0d) expected (314,234)",
               u_dut.u_motion.r_bx, u_dut.u_motion.r_by);
    end
    pause = 1'b0;
  endtask

  task automatic test_reset_mid_update();
    int h0, hc0;
    do_reset();
    speed = 3'd1;
    h0 = hits_dut; hc0 = hits_cor;
    vs = 1'b0;
    strobe();
    tests++;
    if (u_dut.u_motion.r_state !== ST_UPD_X) begin
      fails++;
      $display("FAIL reach_upd_x: got state=%0d expected %0d",
               u_dut.u_motion.r_state, ST_UPD_X);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (u_corner.u_motion.r_state !== ST_WAIT ||
        {u_corner.u_motion.r_bx, u_corner.u_motion.r_by} !== {10'd624, 9'd464}) begin
      fails++;
      $display("FAIL reset_mid_state: got state=%0d pos=(%0d,%0d) expected state=0 pos=(624,464)",
               u_corner.u_motion.r_state, u_corner.u_motion.r_bx, u_corner.u_motion.r_by);
    end
    idle(4);
    tests++;
    if (hits_cor != hc0 || hits_dut != h0) begin
      fails++;
      $display("FAIL reset_mid_hit: got hits dut=%0d corner=%0d expected 0 and 0",
               hits_dut - h0, hits_cor - hc0);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alignment();
    test_corner();
    test_bounce();
    test_pause_speed0();
    test_pause_mid_update();
    test_reset_mid_update();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
